// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: opcodes, PcSrc encodings, NOP word and the fetch FSM state type.
package rv32_pkg;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_IL   = 7'b0000011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_U    = 7'b0110111;
  localparam logic [6:0] OP_AUI  = 7'b0010111;
  localparam logic [6:0] OP_J    = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JAL    = 2'b10;
  localparam logic [1:0] PCSRC_JALR   = 2'b11;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_WAIT,
    ST_HOLD
  } fetch_state_t;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection from PcSrc, plus misaligned-target detection.
// With TRAP_EN a misaligned target is replaced by TRAP_VEC; without it the low bits are cleared.
module pc_next_calc
  import rv32_pkg::*;
#(
  parameter bit          TRAP_EN  = 1'b0,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic [31:0] pc,
  input  logic [1:0]  pc_src,
  input  logic        branch_taken,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_val,
  output logic [31:0] next_pc,
  output logic        misalign
);

  logic [31:0] target;

  always_comb begin
    target = pc + 32'd4;
    case (pc_src)
      PCSRC_PLUS4:  target = pc + 32'd4;
      PCSRC_BRANCH: target = branch_taken ? (pc + imm) : (pc + 32'd4);
      PCSRC_JAL:    target = pc + imm;
      PCSRC_JALR:   target = (rs1_val + imm) & ~32'h1;
      default:      target = pc + 32'd4;
    endcase
  end

  assign misalign = TRAP_EN && (target[1:0] != 2'b00);
  assign next_pc  = misalign ? TRAP_VEC : {target[31:2], 2'b00};

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32I fetch front end: PC register, imem req/rvalid handshake, held instruction for decode.
// Optional misaligned-target trap is enabled by defining MISALIGN_TRAP_EN.
module instr_fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pc_src,
  input  logic        branch_taken,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_val,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic        instr_valid,
  output logic        misalign_trap
);

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  fetch_state_t state;
  logic [31:0]  next_pc;
  logic         misalign;

  pc_next_calc #(
    .TRAP_EN  (TRAP_EN),
    .TRAP_VEC (TRAP_VEC)
  ) u_pc_next (
    .pc           (pc),
    .pc_src       (pc_src),
    .branch_taken (branch_taken),
    .imm          (imm),
    .rs1_val      (rs1_val),
    .next_pc      (next_pc),
    .misalign     (misalign)
  );

  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;
  assign opcode    = instr[6:0];

  // imem_req is registered, so FETCH entered from reset first raises it for a cycle,
  // while FETCH entered from HOLD already has it raised by the advancing edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_FETCH;
      pc            <= RESET_PC;
      instr         <= NOP_INSTR;
      instr_valid   <= 1'b0;
      imem_req      <= 1'b0;
      misalign_trap <= 1'b0;
    end else begin
      misalign_trap <= 1'b0;
      case (state)
        ST_FETCH: begin
          if (imem_req) begin
            imem_req <= 1'b0;
            state    <= ST_WAIT;
          end else begin
            imem_req <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            state       <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            pc            <= next_pc;
            misalign_trap <= misalign;
            instr_valid   <= 1'b0;
            imem_req      <= 1'b1;
            state         <= ST_FETCH;
          end
        end
        default: begin
          imem_req <= 1'b0;
          state    <= ST_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a behavioural imem and a fetch/hold scoreboard.
// Trap expectations follow MISALIGN_TRAP_EN.
module tb_instr_fetch_unit;
  import rv32_pkg::*;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TB_TRAP_VEC = 32'h0000_0100;
`ifdef MISALIGN_TRAP_EN
  localparam logic        TRAP_ON = 1'b1;
  localparam logic [31:0] JALR_DEST = TB_TRAP_VEC;
`else
  localparam logic        TRAP_ON = 1'b0;
  localparam logic [31:0] JALR_DEST = 32'h0000_1000;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pc_src;
  logic        branch_taken;
  logic [31:0] imm;
  logic [31:0] rs1_val;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic        instr_valid;
  logic        misalign_trap;

  int total = 0;
  int bad   = 0;

  logic [31:0] addr_q[$];
  logic [31:0] hold_q[$];
  int          mem_wait = 0;
  bit          inject_stale = 1'b0;
  logic [31:0] cur;

  instr_fetch_unit #(
    .RESET_PC (TB_RESET_PC),
    .TRAP_VEC (TB_TRAP_VEC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_src        (pc_src),
    .branch_taken  (branch_taken),
    .imm           (imm),
    .rs1_val       (rs1_val),
    .stall         (stall),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .instr         (instr),
    .opcode        (opcode),
    .instr_valid   (instr_valid),
    .misalign_trap (misalign_trap)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] gen_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Behavioural imem: answers each request after mem_wait extra cycles, flushes on reset.
  bit          pending = 1'b0;
  bit          inject_done = 1'b0;
  int          wait_cnt = 0;
  logic [31:0] resp_addr = '0;
  always @(negedge clk) begin
    if (rst) begin
      pending     = 1'b0;
      imem_rvalid = 1'b0;
      hold_q.delete();
    end else begin
      imem_rvalid = 1'b0;
      if (inject_stale && !inject_done) begin
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        inject_done = 1'b1;
      end
      if (pending) begin
        if (wait_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = gen_word(resp_addr);
          pending     = 1'b0;
        end else begin
          wait_cnt--;
        end
      end
      if (imem_req) begin
        total++;
        assert (addr_q.size() > 0) else begin
          bad++;
          $error("[TB] FAIL req_unexpected observed=%h expected=no_request", imem_addr);
        end
        if (addr_q.size() > 0) begin
          resp_addr = addr_q.pop_front();
          check_output("imem_addr", imem_addr, resp_addr);
          wait_cnt = mem_wait;
          pending  = 1'b1;
          hold_q.push_back(resp_addr);
        end
      end
    end
  end

  // Scoreboard check on each new held instruction.
  bit prev_valid = 1'b0;
  always @(negedge clk) begin
    logic [31:0] e;
    logic [31:0] w;
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (instr_valid && !prev_valid) begin
        total++;
        assert (hold_q.size() > 0) else begin
          bad++;
          $error("[TB] FAIL hold_unexpected observed=%h expected=no_hold", pc);
        end
        if (hold_q.size() > 0) begin
          e = hold_q.pop_front();
          w = gen_word(e);
          check_output("hold_pc", pc, e);
          check_output("hold_instr", instr, w);
          check_output("hold_opcode", {25'b0, opcode}, {25'b0, w[6:0]});
          check_output("hold_pc_plus4", pc_plus4, e + 32'd4);
        end
      end
      prev_valid = instr_valid;
    end
  end

  task automatic run_to_hold(input int exp_cycles, input logic exp_trap, input bit keep, input string tag);
    int n = 0;
    int reqs = 0;
    bit done = 1'b0;
    while (!done) begin
      @(negedge clk);
      n++;
      if (imem_req) reqs++;
      if (n == 1) begin
        if (!keep) stall = 1'b1;
        check_output({tag, "_trap"}, {31'b0, misalign_trap}, {31'b0, exp_trap});
        check_output({tag, "_valid_drop"}, {31'b0, instr_valid}, 32'd0);
      end
      if (n == 2) check_output({tag, "_trap_end"}, {31'b0, misalign_trap}, 32'd0);
      if (instr_valid || n >= 60) done = 1'b1;
    end
    check_output({tag, "_cycles"}, n, exp_cycles);
    check_output({tag, "_req_pulses"}, reqs, 32'd1);
  endtask

  task automatic apply_stimulus(input logic [1:0] src, input logic taken, input logic [31:0] im,
                                input logic [31:0] rs1, input logic [31:0] exp_addr,
                                input int exp_cycles, input logic exp_trap, input string tag);
    addr_q.push_back(exp_addr);
    pc_src       = src;
    branch_taken = taken;
    imm          = im;
    rs1_val      = rs1;
    stall        = 1'b0;
    run_to_hold(exp_cycles, exp_trap, 1'b0, tag);
    cur = exp_addr;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b1; pc_src = PCSRC_PLUS4; branch_taken = 1'b0;
    imm = '0; rs1_val = '0; imem_rvalid = 1'b0; imem_rdata = '0; cur = TB_RESET_PC;
    repeat (3) @(negedge clk);
    check_output("rst_pc", pc, TB_RESET_PC);
    check_output("rst_instr", instr, NOP_INSTR);
    check_output("rst_valid", {31'b0, instr_valid}, 32'd0);
    check_output("rst_req", {31'b0, imem_req}, 32'd0);
    check_output("rst_trap", {31'b0, misalign_trap}, 32'd0);

    $display("[TB] sequential fetch");
    @(posedge clk); #1 rst = 1'b0;
    addr_q.push_back(32'h0); addr_q.push_back(32'h4); addr_q.push_back(32'h8);
    stall = 1'b0;
    run_to_hold(4, 1'b0, 1'b1, "t1_first");
    run_to_hold(3, 1'b0, 1'b1, "t1_second");
    run_to_hold(3, 1'b0, 1'b1, "t1_third");
    stall = 1'b1;
    cur = 32'h8;

    $display("[TB] branch taken / not taken");
    apply_stimulus(PCSRC_JAL,    1'b0, 32'h8,         '0, 32'h10, 3, 1'b0, "t2_jal");
    apply_stimulus(PCSRC_BRANCH, 1'b1, 32'hFFFF_FFF8, '0, 32'h08, 3, 1'b0, "t2_taken");
    apply_stimulus(PCSRC_JAL,    1'b0, 32'h8,         '0, 32'h10, 3, 1'b0, "t2_jal_back");
    apply_stimulus(PCSRC_BRANCH, 1'b0, 32'hFFFF_FFF8, '0, 32'h14, 3, 1'b0, "t2_not_taken");

    $display("[TB] jalr misaligned target");
    apply_stimulus(PCSRC_JALR, 1'b0, 32'h2, 32'h1001, JALR_DEST, 3, TRAP_ON, "t3_jalr");

    $display("[TB] slow memory and stall");
    mem_wait = 5;
    apply_stimulus(PCSRC_PLUS4, 1'b0, '0, '0, cur + 32'd4, 8, 1'b0, "t4_slow");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_output("t4_stall_pc", pc, cur);
      check_output("t4_stall_instr", instr, gen_word(cur));
      check_output("t4_stall_valid", {31'b0, instr_valid}, 32'd1);
      check_output("t4_stall_req", {31'b0, imem_req}, 32'd0);
    end

    $display("[TB] reset during wait");
    addr_q.push_back(32'h40);
    pc_src = PCSRC_JALR; imm = '0; rs1_val = 32'h40; stall = 1'b0;
    @(negedge clk);
    stall = 1'b1;
    check_output("t5_req", {31'b0, imem_req}, 32'd1);
    @(negedge clk);
    check_output("t5_wait_req", {31'b0, imem_req}, 32'd0);
    #2 rst = 1'b1;
    #1;
    check_output("t5_async_pc", pc, TB_RESET_PC);
    check_output("t5_async_instr", instr, NOP_INSTR);
    check_output("t5_async_valid", {31'b0, instr_valid}, 32'd0);
    check_output("t5_async_req", {31'b0, imem_req}, 32'd0);
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b0;
    mem_wait = 0;
    inject_stale = 1'b1;
    addr_q.push_back(TB_RESET_PC);
    run_to_hold(4, 1'b0, 1'b0, "t5_refetch");
    cur = TB_RESET_PC;

    $display("[TB] pc wrap");
    apply_stimulus(PCSRC_JALR,  1'b0, '0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 3, 1'b0, "t6_top");
    apply_stimulus(PCSRC_PLUS4, 1'b0, '0, '0,            32'h0000_0000, 3, 1'b0, "t6_wrap");

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
